// File: rtl/icache_direct_mapped.sv
// icache_direct_mapped: read-only direct-mapped instruction cache with zero-latency hits and a blocking line fill
module icache_direct_mapped #(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS = 3,
  parameter int LINE_BITS = 128
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [31:0]                    PC,
  output logic [31:0]                    INSTRUCTION,
  output logic                           BUSYWAIT,
  output logic                           MEM_READ,
  output logic [TAG_BITS+INDEX_BITS-1:0] MEM_ADDRESS,
  input  logic [LINE_BITS-1:0]           MEM_READDATA,
  input  logic                           MEM_BUSYWAIT
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int AW = TAG_BITS + INDEX_BITS;
  typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_UPDATE} state_t;
  state_t                state;
  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tag_store [LINES];
  logic [LINE_BITS-1:0]  data_store [LINES];
  logic [LINE_BITS-1:0]  fill_line;
  logic [TAG_BITS-1:0]   tag;
  logic [INDEX_BITS-1:0] index;
  logic [INDEX_BITS-1:0] fill_index;
  logic [1:0]            word;
  logic                  hit;
  logic                  unused_pc;
  assign tag = PC[AW+3:INDEX_BITS+4];
  assign index = PC[INDEX_BITS+3:4];
  assign word = PC[3:2];
  assign unused_pc = ^{PC[31:AW+4], PC[1:0]};
  assign fill_index = MEM_ADDRESS[INDEX_BITS-1:0];
  assign hit = valid[index] && (tag_store[index] == tag);
  assign INSTRUCTION = data_store[index][{word, 5'b0} +: 32];
  // A miss stalls the CPU in the same cycle; reset forces the stall off without a clock edge.
  assign BUSYWAIT = RESET && ((state != S_IDLE) || !hit);
  // Fill controller: latch the line address on a miss, wait for memory, then commit the line.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= S_IDLE;
      MEM_READ <= 1'b0;
      MEM_ADDRESS <= '0;
      valid <= '0;
    end else begin
      case (state)
        S_IDLE: if (!hit) begin
          state <= S_MEM_READ;
          MEM_READ <= 1'b1;
          MEM_ADDRESS <= {tag, index};
        end
        S_MEM_READ: if (!MEM_BUSYWAIT) begin
          state <= S_UPDATE;
          MEM_READ <= 1'b0;
        end
        S_UPDATE: begin
          state <= S_IDLE;
          valid[fill_index] <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  // Line storage: capture the returned line, then write it with its tag using the latched address.
  always_ff @(posedge CLK) begin
    if (state == S_MEM_READ && !MEM_BUSYWAIT) fill_line <= MEM_READDATA;
    if (state == S_UPDATE) begin
      data_store[fill_index] <= fill_line;
      tag_store[fill_index] <= MEM_ADDRESS[AW-1:INDEX_BITS];
    end
  end
endmodule
